// File: rtl/s3_writeback_pkg.sv
// Shared RV32I decode constants and the stage-3 register bundle.
package s3_writeback_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_ARI_I  = 7'b0010011;
    localparam logic [6:0] OPC_ARI_R  = 7'b0110011;
    localparam logic [6:0] OPC_CSR    = 7'b1110011;

    localparam logic [2:0] FNC_LB     = 3'b000;
    localparam logic [2:0] FNC_LH     = 3'b001;
    localparam logic [2:0] FNC_LW     = 3'b010;
    localparam logic [2:0] FNC_LBU    = 3'b100;
    localparam logic [2:0] FNC_LHU    = 3'b101;
    localparam logic [2:0] FNC_CSRRW  = 3'b001;
    localparam logic [2:0] FNC_CSRRWI = 3'b101;

    localparam logic [11:0] CSR_TOHOST  = 12'h51E;
    localparam logic [11:0] CSR_CYCLE   = 12'hC00;
    localparam logic [11:0] CSR_TIME    = 12'hC01;
    localparam logic [11:0] CSR_INSTRET = 12'hC02;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] csr_wdata;
    } s3_regs_t;

endpackage

// File: rtl/s3_writeback_load_extract.sv
// Picks the addressed byte/half/word out of a BRAM read word and extends it.
module s3_load_extract
    import s3_writeback_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] result
);
    logic [3:0][7:0] lanes;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;

    assign lanes    = rdata;
    assign byte_sel = lanes[addr];
    assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        result = 32'h0;
        case (funct3)
            FNC_LB:  result = {{24{byte_sel[7]}}, byte_sel};
            FNC_LBU: result = {24'h0, byte_sel};
            FNC_LH:  result = {{16{half_sel[15]}}, half_sel};
            FNC_LHU: result = {16'h0, half_sel};
            FNC_LW:  result = rdata;
            default: result = 32'h0;
        endcase
    end
endmodule

// File: rtl/s3_writeback.sv
// Pipeline stage 3: stage registers, load extraction, writeback select,
// tohost CSR and cycle/instret counters.
module s3_writeback
    import s3_writeback_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        valid_s2,
    input  logic [31:0] inst_s2,
    input  logic [31:0] pc_s2,
    input  logic [31:0] alu_s2,
    input  logic [31:0] csr_wdata_s2,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] inst_s3,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic [31:0] tohost,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);
    s3_regs_t    s3;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [11:0] csr_addr;
    logic [31:0] load_data;
    logic [31:0] csr_rdata;
    logic        wb_en;
    logic        tohost_wr;
    logic        unused_rs1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s3.inst      <= NOP;
            s3.valid     <= 1'b0;
            s3.pc        <= RESET_PC;
            s3.alu       <= 32'h0;
            s3.csr_wdata <= 32'h0;
        end else if (!stall) begin
            if (flush) begin
                s3.inst      <= NOP;
                s3.valid     <= 1'b0;
                s3.pc        <= 32'h0;
                s3.alu       <= 32'h0;
                s3.csr_wdata <= 32'h0;
            end else begin
                s3.inst      <= inst_s2;
                s3.valid     <= valid_s2;
                s3.pc        <= pc_s2;
                s3.alu       <= alu_s2;
                s3.csr_wdata <= csr_wdata_s2;
            end
        end
    end

    assign inst_s3    = s3.inst;
    assign opc        = s3.inst[6:0];
    assign f3         = s3.inst[14:12];
    assign csr_addr   = s3.inst[31:20];
    assign rf_wa      = s3.inst[11:7];
    assign unused_rs1 = ^s3.inst[19:15];

    s3_load_extract u_load_extract (
        .funct3 (f3),
        .addr   (s3.alu[1:0]),
        .rdata  (dmem_rdata),
        .result (load_data)
    );

    always_comb begin
        csr_rdata = 32'h0;
        case (csr_addr)
            CSR_TOHOST:          csr_rdata = tohost;
            CSR_CYCLE, CSR_TIME: csr_rdata = cycle_cnt;
            CSR_INSTRET:         csr_rdata = instret_cnt;
            default:             csr_rdata = 32'h0;
        endcase
    end

    always_comb begin
        rf_wd = 32'h0;
        wb_en = 1'b0;
        case (opc)
            OPC_LOAD:            begin rf_wd = load_data;           wb_en = 1'b1; end
            OPC_JAL, OPC_JALR:   begin rf_wd = s3.pc + 32'd4;       wb_en = 1'b1; end
            OPC_CSR:             begin rf_wd = csr_rdata;           wb_en = 1'b1; end
            OPC_LUI, OPC_AUIPC,
            OPC_ARI_R, OPC_ARI_I: begin rf_wd = s3.alu;             wb_en = 1'b1; end
            default:             begin rf_wd = 32'h0;               wb_en = 1'b0; end
        endcase
    end

    assign rf_we = wb_en && s3.valid && (rf_wa != 5'd0);

    // CSR read above sees the pre-write tohost; the write lands on this edge.
    assign tohost_wr = !stall && s3.valid && (opc == OPC_CSR) &&
                       ((f3 == FNC_CSRRW) || (f3 == FNC_CSRRWI)) &&
                       (csr_addr == CSR_TOHOST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tohost      <= 32'h0;
            cycle_cnt   <= 32'h0;
            instret_cnt <= 32'h0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (tohost_wr)
                tohost <= s3.csr_wdata;
            if (!stall && s3.valid)
                instret_cnt <= instret_cnt + 32'd1;
        end
    end
endmodule
